// File: rtl/dds_phase_adjuster.sv
// DDS phase-adjust sequencer: measures phase error, spreads it over a work
// window as a temporary frequency offset, then reports completion.
module dds_phase_adjuster #(
  parameter int PW = 32,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic          start,
  input  logic [PW-1:0] freq_base,
  input  logic [PW-1:0] desired_phase,
  input  logic [PW-1:0] phase_in,
  input  logic [CW-1:0] pre_delay,
  input  logic [CW-1:0] work_time,
  input  logic [CW-1:0] post_delay,
  output logic [PW-1:0] freq_out,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [PW-1:0] phase_err
);

  localparam int BW = $clog2(PW);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRE    = 3'd1;
  localparam logic [2:0] S_SAMPLE = 3'd2;
  localparam logic [2:0] S_CALC   = 3'd3;
  localparam logic [2:0] S_WORK   = 3'd4;
  localparam logic [2:0] S_POST   = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] des_q, des_d;
  logic [CW-1:0] work_q, work_d;
  logic [CW-1:0] post_q, post_d;
  logic          neg_q, neg_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [PW-1:0] dq_q, dq_d;
  logic [PW-1:0] off_q, off_d;
  logic [PW-1:0] freq_q, freq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_q, cfg_d;
  logic [PW-1:0] perr_q, perr_d;

  logic [PW-1:0] err;
  logic [PW-1:0] mag;
  logic [CW:0]   rem_sh;
  logic [CW:0]   rem_nx;
  logic          ge;
  logic [PW-1:0] quo_nx;
  logic          last_bit;

  // Restoring divider: dq_q holds the dividend and fills with quotient bits.
  assign err      = des_q - phase_in;
  assign mag      = err[PW-1] ? (~err + 1'b1) : err;
  assign rem_sh   = {rem_q, dq_q[PW-1]};
  assign ge       = rem_sh >= {1'b0, work_q};
  assign rem_nx   = ge ? (rem_sh - {1'b0, work_q}) : rem_sh;
  assign quo_nx   = {dq_q[PW-2:0], ge};
  assign last_bit = bit_q == BW'(PW - 1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    des_d   = des_q;
    work_d  = work_q;
    post_d  = post_q;
    neg_d   = neg_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    off_d   = off_q;
    cfg_d   = cfg_q;
    perr_d  = perr_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE && !ena) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start && ena) begin
            des_d  = desired_phase;
            work_d = work_time;
            post_d = post_delay;
            cfg_d  = 1'b0;
            if (pre_delay == '0) begin
              state_d = S_SAMPLE;
            end else begin
              state_d = S_PRE;
              cnt_d   = pre_delay - 1'b1;
            end
          end
        end
        S_PRE: begin
          if (cnt_q == '0) state_d = S_SAMPLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_SAMPLE: begin
          perr_d = err;
          neg_d  = err[PW-1];
          dq_d   = mag;
          rem_d  = '0;
          bit_d  = '0;
          if (work_q != '0) begin
            state_d = S_CALC;
          end else begin
            cfg_d = 1'b1;
            if (post_q == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_POST;
              cnt_d   = post_q - 1'b1;
            end
          end
        end
        S_CALC: begin
          rem_d = rem_nx[CW-1:0];
          dq_d  = quo_nx;
          bit_d = bit_q + 1'b1;
          if (last_bit) begin
            off_d   = neg_q ? (~quo_nx + 1'b1) : quo_nx;
            state_d = S_WORK;
            cnt_d   = work_q - 1'b1;
          end
        end
        S_WORK: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (post_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_POST;
            cnt_d   = post_q - 1'b1;
          end
        end
        S_POST: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Output word tracks the state being entered so both change together.
    freq_d = (state_d == S_WORK) ? (freq_base + off_d) : freq_base;
    busy_d = state_d != S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      des_q   <= '0;
      work_q  <= '0;
      post_q  <= '0;
      neg_q   <= 1'b0;
      rem_q   <= '0;
      dq_q    <= '0;
      off_q   <= '0;
      freq_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cfg_q   <= 1'b0;
      perr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      des_q   <= des_d;
      work_q  <= work_d;
      post_q  <= post_d;
      neg_q   <= neg_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      off_q   <= off_d;
      freq_q  <= freq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
      perr_q  <= perr_d;
    end
  end

  assign freq_out  = freq_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_q;
  assign phase_err = perr_q;

endmodule

// File: tb/tb_dds_phase_adjuster.sv
// Bench for dds_phase_adjuster: directed runs plus random runs checked
// against a cycle-timeline model derived from the run parameters.
module tb_dds_phase_adjuster;

  localparam int PW = 32;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] freq_base = '0;
  logic [PW-1:0] desired_phase = '0;
  logic [PW-1:0] phase_in = '0;
  logic [CW-1:0] pre_delay = '0;
  logic [CW-1:0] work_time = '0;
  logic [CW-1:0] post_delay = '0;
  logic [PW-1:0] freq_out;
  logic          busy;
  logic          done;
  logic          cfg_err;
  logic [PW-1:0] phase_err;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_perr = '0;
  logic        m_cfg = 1'b0;

  dds_phase_adjuster #(.PW(PW), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .start(start),
    .freq_base(freq_base),
    .desired_phase(desired_phase),
    .phase_in(phase_in),
    .pre_delay(pre_delay),
    .work_time(work_time),
    .post_delay(post_delay),
    .freq_out(freq_out),
    .busy(busy),
    .done(done),
    .cfg_err(cfg_err),
    .phase_err(phase_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  // Cycle k counts edges after the one that samples start (cycle 0).
  task automatic run(input logic [31:0] base, input logic [31:0] des,
                     input logic [31:0] ph, input int pre, input int work,
                     input int post, input int abort_at, input int rst_at,
                     input int restart_at);
    logic [31:0] err, mag, q, off, ef;
    logic eb, ed;
    int calc, d, ws, we, stop, kend;
    err  = des - ph;
    mag  = err[31] ? (32'd0 - err) : err;
    q    = (work > 0) ? 32'(longint'(mag) / longint'(work)) : 32'd0;
    off  = err[31] ? (32'd0 - q) : q;
    calc = (work > 0) ? PW : 0;
    d    = pre + 1 + calc + work + post + 1;
    ws   = pre + 2 + calc;
    we   = ws + work - 1;
    stop = (abort_at > 0) ? abort_at : rst_at;
    kend = (stop > 0) ? stop + 3 : d + 2;
    @(negedge clk);
    freq_base     = base;
    desired_phase = des;
    phase_in      = ph;
    pre_delay     = pre;
    work_time     = work;
    post_delay    = post;
    ena   = 1'b1;
    rst_n = 1'b1;
    start = 1'b1;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_freq", freq_out, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_cfg", cfg_err, 32'd0);
        chk("rst_perr", phase_err, 32'd0);
      end else begin
        if (stop > 0 && k > stop) begin
          ef = base; eb = 1'b0; ed = 1'b0;
        end else begin
          eb = k < d;
          ed = k == d;
          ef = (k >= ws && k <= we) ? base + off : base;
        end
        chk("freq", freq_out, ef);
        chk("busy", busy, eb);
        chk("done", done, ed);
      end
      start = (k == restart_at);
      ena   = (k != abort_at);
      rst_n = (k != rst_at);
      desired_phase = $urandom;
      pre_delay     = $urandom_range(0, 9);
      work_time     = $urandom_range(0, 9);
      post_delay    = $urandom_range(0, 9);
    end
    m_cfg = 1'b0;
    if (stop == 0 || stop > pre + 1) begin
      m_perr = err;
      m_cfg  = (work == 0);
    end
    if (rst_at > 0) begin
      m_perr = '0;
      m_cfg  = 1'b0;
    end
    chk("phase_err", phase_err, m_perr);
    chk("cfg_err", cfg_err, m_cfg);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_freq", freq_out, 32'd0);
    chk("reset_busy", busy, 32'd0);
    chk("reset_done", done, 32'd0);
    chk("reset_cfg", cfg_err, 32'd0);
    chk("reset_perr", phase_err, 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    run(32'h0100_0000, 32'h0000_1000, 32'h0, 10, 16, 5, 0, 0, 0);
    chk("t1_perr", phase_err, 32'h0000_1000);
    run(32'h0100_0000, 32'h0, 32'h0000_0100, 2, 3, 1, 0, 0, 0);
    chk("t2_perr", phase_err, 32'hFFFF_FF00);
    run(32'h0200_0000, 32'h0000_0010, 32'hFFFF_FFF0, 1, 32, 2, 0, 0, 0);
    chk("t3_perr", phase_err, 32'h0000_0020);
    run(32'h0300_0000, 32'h1234_5678, 32'h0, 0, 0, 2, 0, 0, 0);
    chk("t4_cfg", cfg_err, 32'd1);
    run(32'h0400_0000, 32'h0001_0000, 32'h0, 3, 8, 2, 39, 0, 0);
    run(32'h0500_0000, 32'h0000_0300, 32'h0, 1, 4, 1, 0, 0, 0);
    run(32'h0600_0000, 32'h0000_0040, 32'h0, 2, 4, 3, 0, 0, 7);
    run(32'h0700_0000, 32'h0000_0400, 32'h0, 1, 2, 4, 0, 38, 0);
    run(32'h0800_0000, 32'h8000_0000, 32'h0, 0, 1, 0, 0, 0, 0);
    run(32'h0900_0000, 32'h0, 32'h8000_0000, 1, 3, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int pre, work, post, d, ab, rs, rq, sel;
      pre  = $urandom_range(0, 6);
      work = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20);
      post = $urandom_range(0, 4);
      d    = pre + 1 + ((work > 0) ? PW : 0) + work + post + 1;
      sel  = $urandom_range(0, 7);
      ab   = 0;
      rs   = 0;
      rq   = 0;
      if (sel == 0) ab = $urandom_range(1, d - 1);
      if (sel == 1) rs = $urandom_range(1, d - 1);
      if (sel == 2 || sel == 3) rq = $urandom_range(1, d - 1);
      if (sel == 3 && rq > 1) ab = $urandom_range(rq, d - 1);
      run($urandom, $urandom, $urandom, pre, work, post, ab, rs, rq);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
